// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: halt FSM encoding and
// default PC vectors.
package pc_pkg;
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
endpackage

// File: rtl/pc_halt_fsm.sv
// Run/halt/single-step control that gates fetch requests from the PC unit.
module pc_halt_fsm
    import pc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      halt_req,
    input  logic      resume,
    input  logic      step,
    input  logic      fire,
    input  logic      redirect_valid,
    input  logic      trap,
    output pc_state_t state,
    output logic      fetch_valid,
    output logic      halted
);
    pc_state_t next_state;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (halt_req) next_state = HALT;
            HALT: begin
                if (resume)    next_state = RUN;
                else if (step) next_state = STEP;
            end
            // Any control-flow change ends the single step, not just a fetch.
            STEP:    if (fire || redirect_valid || trap) next_state = HALT;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        fetch_valid = ((state == RUN) && !halt_req) || (state == STEP);
        halted      = (state == HALT);
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential advance, trap/redirect priority mux,
// trap EPC capture and an advance counter, gated by the halt FSM.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  PC_STEP      = XLEN'(1),
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
    parameter int               CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             step,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             trap,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_seq_out,
    output logic             fetch_valid,
    output logic             halted,
    output logic [XLEN-1:0]  epc,
    output logic [CNT_W-1:0] adv_count
);
    pc_state_t state;
    logic      fire;
    logic      redir_take;

    assign fire       = fetch_valid && fetch_ready && !stall;
    assign redir_take = redirect_valid && (state != HALT);
    assign pc_seq_out = pc_out + PC_STEP;

    pc_halt_fsm u_fsm (
        .clk            (clk),
        .rst            (rst),
        .halt_req       (halt_req),
        .resume         (resume),
        .step           (step),
        .fire           (fire),
        .redirect_valid (redir_take),
        .trap           (trap),
        .state          (state),
        .fetch_valid    (fetch_valid),
        .halted         (halted)
    );

    // Trap beats redirect beats sequential; the counter only sees the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out    <= RESET_VECTOR;
            epc       <= '0;
            adv_count <= '0;
        end else if (trap) begin
            pc_out <= TRAP_VECTOR;
            epc    <= pc_out;
        end else if (redir_take) begin
            pc_out <= redirect_pc;
        end else if (fire) begin
            pc_out    <= pc_seq_out;
            adv_count <= adv_count + CNT_W'(1);
        end
    end
endmodule
